debounce_multi: RTL and testbench

- Parametrised multi-channel push-button/switch conditioner. Successor to the single-button shift-register debouncer.
- Per channel: synchroniser, counter-based stability filter, debounced level, one-cycle press/release pulses and optional hold-to-auto-repeat.
- Sits between board inputs and the ALU operand/opcode entry FSM. Replaces per-button debouncer instances with one block.

---
 rtl/debounce_multi_pkg.sv | 21 ++
 rtl/debounce_channel.sv | 91 +++++++++
 rtl/debounce_multi.sv | 39 +++
 tb/tb_debounce_multi.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/debounce_multi_pkg.sv
// Shared constants and width helpers for the multi-channel button debouncer.
// Timing defaults assume a 50 MHz system clock.
package debounce_multi_pkg;

  localparam int DB_STABLE_10MS  = 500000;
  localparam int RPT_DELAY_500MS = 25000000;
  localparam int RPT_RATE_100MS  = 5000000;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int v = value - 1; v > 0; v = v >> 1) width++;
    return width;
  endfunction

  // A counter that must reach terminal-1 needs at least one bit even when terminal is 1
  function automatic int cnt_width(input int terminal);
    return (clog2(terminal) < 1) ? 1 : clog2(terminal);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-bit button conditioner: synchroniser, stability filter,
// press/release pulse generation and optional hold-to-repeat.
module debounce_channel
  import debounce_multi_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_CNT   = DB_STABLE_10MS,
  parameter int ACTIVE_LOW   = 0,
  parameter int REPEAT_EN    = 0,
  parameter int REPEAT_DELAY = RPT_DELAY_500MS,
  parameter int REPEAT_RATE  = RPT_RATE_100MS
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int CW = cnt_width(STABLE_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);
  localparam logic IDLE = (ACTIVE_LOW != 0);
  localparam logic [SYNC_STAGES-1:0] SYNC_IDLE = {SYNC_STAGES{IDLE}};

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   s;
  logic                   settle;
  logic                   rise;
  logic                   fall;
  logic                   rpt_hit;

  assign s      = sync[SYNC_STAGES-1] ^ IDLE;
  assign settle = (s != level) && (cnt == CNT_LAST);
  assign rise   = settle & s;
  assign fall   = settle & ~s;

  // Any disagreement shorter than STABLE_CNT cycles restarts the count from zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= SYNC_IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      press <= rise | rpt_hit;
      rel   <= fall;
    end
  end

  if (REPEAT_EN != 0) begin : g_rpt
    localparam int RW = cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    logic [RW-1:0] rpt_cnt;
    logic          phase;

    // phase=0 waits out the long initial delay, phase=1 paces the following repeats
    assign rpt_hit = level && !fall && (rpt_cnt == (phase ? RATE_LAST : DELAY_LAST));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rpt_cnt <= '0;
        phase   <= 1'b0;
      end else if (!level || fall) begin
        rpt_cnt <= '0;
        phase   <= 1'b0;
      end else if (rpt_hit) begin
        rpt_cnt <= '0;
        phase   <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end else begin : g_no_rpt
    assign rpt_hit = 1'b0;
  end

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel button conditioner: one independent debounce_channel per input bit.
module debounce_multi
  import debounce_multi_pkg::*;
#(
  parameter int N_CH         = 5,
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_CNT   = DB_STABLE_10MS,
  parameter int ACTIVE_LOW   = 0,
  parameter int REPEAT_EN    = 0,
  parameter int REPEAT_DELAY = RPT_DELAY_500MS,
  parameter int REPEAT_RATE  = RPT_RATE_100MS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CNT   (STABLE_CNT),
      .ACTIVE_LOW   (ACTIVE_LOW),
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[i]),
      .level (btn_level[i]),
      .press (btn_press[i]),
      .rel   (btn_release[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: three configurations (plain, auto-repeat,
// active-low) share clock and reset; every press/release pulse must match a queued event.
module tb_debounce_multi;

  logic       clk;
  logic       rst;
  logic [1:0] btn_a;
  logic [1:0] btn_r;
  logic [1:0] btn_l;
  logic [1:0] level_o   [3];
  logic [1:0] press_o   [3];
  logic [1:0] release_o [3];

  int unsigned edge_n = 0;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];

  debounce_multi #(
    .N_CH(2), .SYNC_STAGES(2), .STABLE_CNT(4), .ACTIVE_LOW(0),
    .REPEAT_EN(0), .REPEAT_DELAY(8), .REPEAT_RATE(3)
  ) dut_a (
    .clk(clk), .rst(rst), .btn_raw(btn_a),
    .btn_level(level_o[0]), .btn_press(press_o[0]), .btn_release(release_o[0])
  );

  debounce_multi #(
    .N_CH(2), .SYNC_STAGES(2), .STABLE_CNT(4), .ACTIVE_LOW(0),
    .REPEAT_EN(1), .REPEAT_DELAY(8), .REPEAT_RATE(3)
  ) dut_r (
    .clk(clk), .rst(rst), .btn_raw(btn_r),
    .btn_level(level_o[1]), .btn_press(press_o[1]), .btn_release(release_o[1])
  );

  debounce_multi #(
    .N_CH(2), .SYNC_STAGES(2), .STABLE_CNT(4), .ACTIVE_LOW(1),
    .REPEAT_EN(0), .REPEAT_DELAY(8), .REPEAT_RATE(3)
  ) dut_l (
    .clk(clk), .rst(rst), .btn_raw(btn_l),
    .btn_level(level_o[2]), .btn_press(press_o[2]), .btn_release(release_o[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic logic [63:0] ev_pack(input int d, input int c, input int k, input int unsigned at);
    return {8'(d), 8'(c), 8'(k), 8'd0, 32'(at)};
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // k=0 is a press pulse, k=1 a release pulse; order of scan matches push order for same-edge events
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < 2; k++) begin
          logic        pulse;
          logic [63:0] obs;
          pulse = (k == 0) ? press_o[d][c] : release_o[d][c];
          if (pulse === 1'b1) begin
            obs = ev_pack(d, c, k, edge_n);
            if (exp_q.size() == 0)
              check_output("unexpected_pulse", obs, 64'hFFFF_FFFF_FFFF_FFFF);
            else
              check_output("pulse_event", obs, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int unsigned b;

    rst   = 1'b0;
    btn_a = 2'b00;
    btn_r = 2'b00;
    btn_l = 2'b11;
    wait_neg(3);
    check_output("rst_level_a", level_o[0], 2'b00);
    check_output("rst_level_l", level_o[2], 2'b00);
    check_output("rst_press_a", press_o[0], 2'b00);
    rst = 1'b1;
    wait_neg(10);
    check_output("idle_level_a", level_o[0], 2'b00);
    check_output("idle_level_l", level_o[2], 2'b00);

    $display("[TB] clean press and long hold without repeat");
    b = edge_n;
    btn_a[0] = 1'b1;
    exp_q.push_back(ev_pack(0, 0, 0, b + 6));
    wait_neg(5);
    check_output("press_level_pre", level_o[0], 2'b00);
    wait_neg(1);
    check_output("press_level_post", level_o[0], 2'b01);
    wait_neg(14);
    check_output("hold_level", level_o[0], 2'b01);
    check_output("press_drained", 64'(exp_q.size()), 0);

    $display("[TB] release");
    b = edge_n;
    btn_a[0] = 1'b0;
    exp_q.push_back(ev_pack(0, 0, 1, b + 6));
    wait_neg(5);
    check_output("release_level_pre", level_o[0], 2'b01);
    wait_neg(1);
    check_output("release_level_post", level_o[0], 2'b00);
    wait_neg(4);
    check_output("release_drained", 64'(exp_q.size()), 0);

    $display("[TB] bounce");
    b = edge_n;
    btn_a[0] = 1'b1;
    exp_q.push_back(ev_pack(0, 0, 0, b + 10));
    wait_neg(2);
    btn_a[0] = 1'b0;
    wait_neg(2);
    btn_a[0] = 1'b1;
    wait_neg(5);
    check_output("bounce_level_pre", level_o[0], 2'b00);
    wait_neg(1);
    check_output("bounce_level_post", level_o[0], 2'b01);
    wait_neg(4);
    b = edge_n;
    btn_a[0] = 1'b0;
    exp_q.push_back(ev_pack(0, 0, 1, b + 6));
    wait_neg(8);
    check_output("bounce_release_level", level_o[0], 2'b00);
    check_output("bounce_drained", 64'(exp_q.size()), 0);

    $display("[TB] simultaneous press then reset mid-count");
    b = edge_n;
    btn_a = 2'b11;
    exp_q.push_back(ev_pack(0, 0, 0, b + 6));
    exp_q.push_back(ev_pack(0, 1, 0, b + 6));
    wait_neg(6);
    check_output("dual_level", level_o[0], 2'b11);
    btn_a[0] = 1'b0;
    wait_neg(3);
    rst = 1'b0;
    #1;
    check_output("async_rst_level", level_o[0], 2'b00);
    check_output("async_rst_pulses", {press_o[0], release_o[0]}, 4'b0000);
    wait_neg(2);
    check_output("held_rst_level", level_o[0], 2'b00);
    rst = 1'b1;
    b = edge_n;
    exp_q.push_back(ev_pack(0, 1, 0, b + 6));
    wait_neg(5);
    check_output("post_rst_level_pre", level_o[0], 2'b00);
    wait_neg(1);
    check_output("post_rst_level_post", level_o[0], 2'b10);
    wait_neg(2);
    b = edge_n;
    btn_a[1] = 1'b0;
    exp_q.push_back(ev_pack(0, 1, 1, b + 6));
    wait_neg(8);
    check_output("post_rst_release_level", level_o[0], 2'b00);
    check_output("rst_drained", 64'(exp_q.size()), 0);

    $display("[TB] auto-repeat");
    b = edge_n;
    btn_r[0] = 1'b1;
    exp_q.push_back(ev_pack(1, 0, 0, b + 6));
    for (int k = 0; k < 8; k++) exp_q.push_back(ev_pack(1, 0, 0, b + 14 + 3 * k));
    wait_neg(15);
    check_output("repeat_level_mid", level_o[1], 2'b01);
    wait_neg(15);
    btn_r[0] = 1'b0;
    exp_q.push_back(ev_pack(1, 0, 1, b + 36));
    wait_neg(12);
    check_output("repeat_level_end", level_o[1], 2'b00);
    check_output("repeat_drained", 64'(exp_q.size()), 0);

    $display("[TB] active-low input");
    b = edge_n;
    btn_l[0] = 1'b0;
    exp_q.push_back(ev_pack(2, 0, 0, b + 6));
    wait_neg(5);
    check_output("al_level_pre", level_o[2], 2'b00);
    wait_neg(1);
    check_output("al_level_post", level_o[2], 2'b01);
    wait_neg(4);
    b = edge_n;
    btn_l[0] = 1'b1;
    exp_q.push_back(ev_pack(2, 0, 1, b + 6));
    wait_neg(8);
    check_output("al_release_level", level_o[2], 2'b00);
    check_output("al_drained", 64'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
